maze_path_tracker: RTL
======================

# maze_path_tracker

Downstream consumer of the maze-solving rat's move stream. Captures each 2-bit `Move` the solver emits, buffers the path in an internal FIFO, and once the solver reports `Done` replays the path as absolute (X, Y) coordinates over a valid/ready stream to the display or checker stage. On solver `Fail` it drops the path and flags failure. Grid bounds are checked during replay.

## Interface
- `N`, 4: coordinate width. Grid is 2^N x 2^N.
- `DIRECTION_SIZE`, 2: width of `Move`.
- `DEPTH_LOG`, 4: FIFO depth is 2^DEPTH_LOG moves.
- `START_X`, 0: X coordinate the path starts from.
- `START_Y`, 0: Y coordinate the path starts from.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  reset, asynchronous and active-low.
- `Clear`  in  1  synchronous pulse; empties the FIFO, zeroes counters, clears flags, returns to CAPTURE.
- `Move_valid`  in  1  a move is present on `Move` this cycle.
- `Move`  in  DIRECTION_SIZE  00 up (Y-1), 01 right (X+1), 10 left (X-1), 11 down (Y+1).
- `Done`  in  1  solver found the path (level).
- `Fail`  in  1  solver found no path (level).
- `Out_valid`  out  1  `Out_X`/`Out_Y`/`Out_last` are valid.
- `Out_ready`  in  1  downstream accepts the current beat.
- `Out_X`, `Out_Y`  out  N  coordinate reached after applying the move.
- `Out_last`  out  1  the current beat is the final move of the path.
- `Path_len`  out  DEPTH_LOG+1  number of moves accepted into the FIFO.
- `Complete`  out  1  replay has finished.
- `Failed`  out  1  the solver reported failure.
- `Overflow`  out  1  sticky; a move arrived while the FIFO was full.
- `Bad_move`  out  1  sticky; the replay left the grid.

## Operation
- States: CAPTURE, DRAIN, COMPLETE, FAILED. Reset and `Clear` both go to CAPTURE.
- Priority, highest first: `RST`, `Clear`, then the state logic.
- **CAPTURE**
  - `Move_valid`=1 with the FIFO not full: push `Move` and increment `Path_len`.
  - `Move_valid`=1 with the FIFO full: drop the move, set `Overflow`, leave `Path_len` unchanged.
  - `Fail`=1: go to FAILED. `Fail` beats `Done` if both are high in the same cycle.
  - `Done`=1 with the FIFO non-empty: go to DRAIN.
  - `Done`=1 with the FIFO empty: go to COMPLETE.
  - A `Move_valid` in the same cycle as `Done` or `Fail` is still captured before the transition.
- **DRAIN**
  - The head move is applied to a position register that starts at (`START_X`, `START_Y`). The result is presented on `Out_X`/`Out_Y`.
  - On handshake (`Out_valid`=1 and `Out_ready`=1): pop the FIFO and advance the position.
  - `Out_last`=1 when the FIFO holds exactly one entry.
  - Handshake on the last beat: go to COMPLETE.
  - `Move_valid`, `Done` and `Fail` are ignored.
- **COMPLETE**: `Complete`=1. Stays here until `Clear`. Inputs are ignored.
- **FAILED**: `Failed`=1. The FIFO is flushed (count 0) and `Path_len` holds its value. Stays here until `Clear`.
- **Grid arithmetic**
  - Coordinates use modulo 2^N arithmetic.
  - X-1 at 0, Y-1 at 0, X+1 at 2^N-1, or Y+1 at 2^N-1: sets `Bad_move`, the wrapped value is output, and replay continues.
- `Path_len` never exceeds 2^DEPTH_LOG.

## Timing
- Reset values:
  - `Out_valid`=0, `Out_last`=0, `Complete`=0, `Failed`=0, `Overflow`=0, `Bad_move`=0.
  - `Path_len`=0, `Out_X`=`START_X`, `Out_Y`=`START_Y`.
  - FIFO empty, state CAPTURE.
- All outputs are registered.
- A move is pushed on the edge where `Move_valid` is sampled. `Path_len` updates one cycle after that.
- `Done` is sampled at edge t. The first `Out_valid`=1 appears after edge t+1, i.e. a latency of 2 cycles from `Done` to the first beat.
- While `Out_ready`=0, `Out_valid`, `Out_X`, `Out_Y` and `Out_last` hold stable. `Out_valid` never drops without a handshake, except on `Clear` or reset.
- With `Out_ready` held at 1, throughput is one beat per cycle.
- `Complete` rises on the edge after the last handshake. At the same edge `Out_valid` falls.
- `Failed` rises on the edge after `Fail` is sampled.
- `Clear` mid-DRAIN: `Out_valid`=0 on the next cycle and no further beats are emitted.
- Reset mid-operation: outputs take their reset values immediately, without waiting for `CLK`.

## Test plan
- Move stream 01,01,11,11, then `Done`, with `Out_ready`=1 -> beats (1,0),(2,0),(2,1),(2,2). `Out_last` only on the 4th beat. `Path_len`=4. `Complete`=1 one cycle after the 4th beat.
- Same stream, with `Out_ready` toggling 1,0,0,1,... -> identical beat sequence. Outputs are held while ready is low. No beat is duplicated or lost.
- 17 moves with `DEPTH_LOG`=4 -> `Overflow`=1, `Path_len`=16, 16 beats replayed.
- Move 00 from (0,0), then `Done` -> `Out_Y`=2^N-1 (15), `Bad_move`=1.
- Two moves, then `Fail` and `Done` asserted together -> FAILED, `Failed`=1, `Out_valid` stays 0, `Path_len`=2. `Clear` then returns to CAPTURE with all flags 0.
- `Done` with no moves -> `Complete`=1 two cycles later, no beats. Separately, `RST` driven low mid-DRAIN -> all outputs at reset values immediately.

Source files
------------

// File: rtl/maze_path_tracker.sv
// rtl/maze_path_tracker.sv - buffers solver moves and replays them as absolute grid coordinates
module maze_path_tracker #(
    parameter int N              = 4,
    parameter int DIRECTION_SIZE = 2,
    parameter int DEPTH_LOG      = 4,
    parameter int START_X        = 0,
    parameter int START_Y        = 0
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      Clear,
    input  logic                      Move_valid,
    input  logic [DIRECTION_SIZE-1:0] Move,
    input  logic                      Done,
    input  logic                      Fail,
    output logic                      Out_valid,
    input  logic                      Out_ready,
    output logic [N-1:0]              Out_X,
    output logic [N-1:0]              Out_Y,
    output logic                      Out_last,
    output logic [DEPTH_LOG:0]        Path_len,
    output logic                      Complete,
    output logic                      Failed,
    output logic                      Overflow,
    output logic                      Bad_move
);
    localparam logic [DEPTH_LOG:0] FULL_CNT = (DEPTH_LOG+1)'(1 << DEPTH_LOG);
    localparam logic [N-1:0]       X0       = N'(START_X);
    localparam logic [N-1:0]       Y0       = N'(START_Y);

    typedef enum logic [1:0] {CAPTURE, DRAIN, COMPLETE, FAILED} state_t;

    state_t                    state, state_next;
    logic [DIRECTION_SIZE-1:0] mem [1 << DEPTH_LOG];
    logic [DEPTH_LOG-1:0]      wr_ptr, rd_ptr, rd_ptr_inc;
    logic [DEPTH_LOG:0]        count;
    logic [N-1:0]              pos_x, pos_y;

    logic                      push, pop, load, flush, overflow_set, last_n, wrap;
    logic [N-1:0]              base_x, base_y, nx, ny;
    logic [DIRECTION_SIZE-1:0] mv;

    assign rd_ptr_inc = rd_ptr + DEPTH_LOG'(1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)       state <= CAPTURE;
        else if (Clear) state <= CAPTURE;
        else            state <= state_next;
    end

    always_comb begin
        state_next   = state;
        push         = 1'b0;
        pop          = 1'b0;
        load         = 1'b0;
        overflow_set = 1'b0;
        base_x       = pos_x;
        base_y       = pos_y;
        mv           = mem[rd_ptr];
        case (state)
            CAPTURE: begin
                if (Move_valid) begin
                    if (count == FULL_CNT) overflow_set = 1'b1;
                    else                   push         = 1'b1;
                end
                if (Fail)
                    state_next = FAILED;
                else if (Done)
                    state_next = (count != '0 || push) ? DRAIN : COMPLETE;
            end
            DRAIN: begin
                if (!Out_valid) begin
                    load = 1'b1;
                end else if (Out_ready) begin
                    pop = 1'b1;
                    if (count == (DEPTH_LOG+1)'(1)) begin
                        state_next = COMPLETE;
                    end else begin
                        // Chain the next beat off the one just accepted to keep one beat per cycle
                        load   = 1'b1;
                        base_x = Out_X;
                        base_y = Out_Y;
                        mv     = mem[rd_ptr_inc];
                    end
                end
            end
            default: ;
        endcase
        flush  = (state_next == FAILED);
        last_n = pop ? (count == (DEPTH_LOG+1)'(2)) : (count == (DEPTH_LOG+1)'(1));
    end

    always_comb begin
        nx   = base_x;
        ny   = base_y;
        wrap = 1'b0;
        case (mv[1:0])
            2'b00: begin ny = base_y - N'(1); wrap = (base_y == '0); end
            2'b01: begin nx = base_x + N'(1); wrap = &base_x;        end
            2'b10: begin nx = base_x - N'(1); wrap = (base_x == '0); end
            default: begin ny = base_y + N'(1); wrap = &base_y;      end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= Move;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0; rd_ptr <= '0; count <= '0; Path_len <= '0;
            pos_x <= X0; pos_y <= Y0; Out_X <= X0; Out_Y <= Y0;
            Out_valid <= 1'b0; Out_last <= 1'b0; Complete <= 1'b0;
            Failed <= 1'b0; Overflow <= 1'b0; Bad_move <= 1'b0;
        end else if (Clear) begin
            wr_ptr <= '0; rd_ptr <= '0; count <= '0; Path_len <= '0;
            pos_x <= X0; pos_y <= Y0; Out_X <= X0; Out_Y <= Y0;
            Out_valid <= 1'b0; Out_last <= 1'b0; Complete <= 1'b0;
            Failed <= 1'b0; Overflow <= 1'b0; Bad_move <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + DEPTH_LOG'(1);
                Path_len <= Path_len + (DEPTH_LOG+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
                pos_x  <= Out_X;
                pos_y  <= Out_Y;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else if (push && !pop) begin
                count <= count + (DEPTH_LOG+1)'(1);
            end else if (pop && !push) begin
                count <= count - (DEPTH_LOG+1)'(1);
            end
            if (overflow_set) Overflow <= 1'b1;
            if (load) begin
                Out_valid <= 1'b1;
                Out_X     <= nx;
                Out_Y     <= ny;
                Out_last  <= last_n;
                if (wrap) Bad_move <= 1'b1;
            end else if (pop) begin
                Out_valid <= 1'b0;
                Out_last  <= 1'b0;
            end
            if ((pop && !load) || state == COMPLETE) Complete <= 1'b1;
            if (state == FAILED) Failed <= 1'b1;
        end
    end
endmodule
